// File: rtl/dm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dm_store_buffer
// Purpose  : Posted-write FIFO between the store unit and data memory, with
//            load-hazard detection. Optional store coalescing: STBUF_COALESCE_EN
// Revision : 1.0 - initial release
// ============================================================================
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   st_valid_in,
    input  logic [AW-1:0]          st_addr_in,
    input  logic [DW-1:0]          st_data_in,
    input  logic [DW/8-1:0]        st_mask_in,
    output logic                   st_ready_out,
    input  logic                   ld_req_in,
    input  logic [AW-1:0]          ld_addr_in,
    output logic                   ld_stall_out,
    output logic                   mem_wr_valid_out,
    input  logic                   mem_wr_ready_in,
    output logic [AW-1:0]          mem_addr_out,
    output logic [DW-1:0]          mem_data_out,
    output logic [DW/8-1:0]        mem_mask_out,
    output logic                   buf_empty_out,
    output logic [$clog2(DEPTH):0] buf_count_out
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_mw    = DW / 8;
    localparam int c_waw   = AW - 2;

    logic [c_waw-1:0]   r_addr [DEPTH];
    logic [DW-1:0]      r_data [DEPTH];
    logic [c_mw-1:0]    r_mask [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_not_empty;
    logic               w_full;
    logic               w_merge_hit;
    logic               w_accept;
    logic               w_push;
    logic               w_merge;
    logic               w_pop;
    logic               w_hit;
    logic [c_ptr_w-1:0] w_young;
    logic [c_waw-1:0]   w_st_word;
    logic [c_waw-1:0]   w_ld_word;
    logic [1:0]         w_unused_lsbs;

    assign w_st_word     = st_addr_in[AW-1:2];
    assign w_ld_word     = ld_addr_in[AW-1:2];
    assign w_unused_lsbs = st_addr_in[1:0] ^ ld_addr_in[1:0];
    assign w_not_empty   = (r_count != '0);
    assign w_full        = (r_count == c_cnt_w'(DEPTH));
    assign w_young       = r_wr_ptr - 1'b1;

`ifdef STBUF_COALESCE_EN
    // Merging into the head while it is the only entry could race the drain.
    assign w_merge_hit = (r_count > c_cnt_w'(1)) && (r_addr[w_young] == w_st_word);
`else
    assign w_merge_hit = 1'b0;
`endif

    assign st_ready_out = !w_full || w_merge_hit;
    assign w_accept     = st_valid_in && st_ready_out && (st_mask_in != '0);
    assign w_merge      = w_accept && w_merge_hit;
    assign w_push       = w_accept && !w_merge_hit;
    assign w_pop        = w_not_empty && mem_wr_ready_in;

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == w_ld_word)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign ld_stall_out     = ld_req_in && w_hit;
    assign mem_wr_valid_out = w_not_empty;
    assign mem_addr_out     = w_not_empty ? {r_addr[r_rd_ptr], 2'b00} : '0;
    assign mem_data_out     = w_not_empty ? r_data[r_rd_ptr] : '0;
    assign mem_mask_out     = w_not_empty ? r_mask[r_rd_ptr] : '0;
    assign buf_empty_out    = !w_not_empty;
    assign buf_count_out    = r_count;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_mask[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_wr_ptr] <= w_st_word;
                r_data[r_wr_ptr] <= st_data_in;
                r_mask[r_wr_ptr] <= st_mask_in;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_merge) begin
                for (int b = 0; b < c_mw; b++) begin
                    if (st_mask_in[b]) begin
                        r_data[w_young][8*b +: 8] <= st_data_in[8*b +: 8];
                    end
                end
                r_mask[w_young] <= r_mask[w_young] | st_mask_in;
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            // Push and pop never share an index: that needs count 0 or DEPTH.
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_store_buffer
// Purpose  : Directed plus randomized bench for dm_store_buffer against a
//            queue-based model of the posted-write buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic        st_ready;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_mask;
    logic        buf_empty;
    logic [2:0]  buf_count;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
        logic [3:0]  m;
    } ent_t;

    ent_t q[$];

    dm_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .st_valid_in      (st_valid),
        .st_addr_in       (st_addr),
        .st_data_in       (st_data),
        .st_mask_in       (st_mask),
        .st_ready_out     (st_ready),
        .ld_req_in        (ld_req),
        .ld_addr_in       (ld_addr),
        .ld_stall_out     (ld_stall),
        .mem_wr_valid_out (mem_valid),
        .mem_wr_ready_in  (mem_ready),
        .mem_addr_out     (mem_addr),
        .mem_data_out     (mem_data),
        .mem_mask_out     (mem_mask),
        .buf_empty_out    (buf_empty),
        .buf_count_out    (buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    function automatic bit model_merge_hit();
`ifdef STBUF_COALESCE_EN
        return (q.size() >= 2) && (q[q.size()-1].w == st_addr[31:2]);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_ready();
        return (q.size() < DEPTH) || model_merge_hit();
    endfunction

    function automatic bit model_stall();
        bit hit = 1'b0;
        foreach (q[i]) if (q[i].w == ld_addr[31:2]) hit = 1'b1;
        return ld_req && hit;
    endfunction

    task automatic compare_all();
        check("count", 32'(buf_count), 32'(q.size()));
        check("empty", 32'(buf_empty), 32'(q.size() == 0));
        check("ready", 32'(st_ready), 32'(model_ready()));
        check("valid", 32'(mem_valid), 32'(q.size() != 0));
        check("stall", 32'(ld_stall), 32'(model_stall()));
        if (q.size() != 0) begin
            check("head_addr", mem_addr, {q[0].w, 2'b00});
            check("head_data", mem_data, q[0].d);
            check("head_mask", 32'(mem_mask), 32'(q[0].m));
        end
    endtask

    task automatic model_update();
        bit   acc;
        bit   mrg;
        bit   pop;
        ent_t e;
        acc = st_valid && model_ready() && (st_mask != 4'b0);
        mrg = acc && model_merge_hit();
        pop = (q.size() != 0) && mem_ready;
        if (mrg) begin
            e = q[q.size()-1];
            for (int b = 0; b < 4; b++) if (st_mask[b]) e.d[8*b +: 8] = st_data[8*b +: 8];
            e.m = e.m | st_mask;
            q[q.size()-1] = e;
        end
        if (pop) void'(q.pop_front());
        if (acc && !mrg) begin
            e.w = st_addr[31:2];
            e.d = st_data;
            e.m = st_mask;
            q.push_back(e);
        end
    endtask

    // Compare on the falling edge, then advance the model across the rising edge.
    task automatic step();
        @(negedge clk);
        compare_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_mask  = m;
        step();
        st_valid = 1'b0;
        st_addr  = 32'h0;
    endtask

    initial begin
        rst_n     = 1'b0;
        st_valid  = 1'b0;
        st_addr   = 32'h0;
        st_data   = 32'h0;
        st_mask   = 4'h0;
        ld_req    = 1'b0;
        ld_addr   = 32'h0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(mem_valid), 32'h0);
        check("rst_ready", 32'(st_ready), 32'h1);
        check("rst_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        step();

        // Fill while memory stalls; head must hold steady and a 5th store bounces.
        for (int i = 0; i < 4; i++) put(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
        check("full_count", 32'(buf_count), 32'd4);
        check("full_ready", 32'(st_ready), 32'h0);
        put(32'h110, 32'hDEAD_BEEF, 4'hF);
        check("full_reject", 32'(buf_count), 32'd4);
        check("stable_addr", mem_addr, 32'h100);

        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_order", mem_addr, 32'h100 + 32'(4 * i));
            step();
        end
        check("drained_empty", 32'(buf_empty), 32'h1);
        mem_ready = 1'b0;

        // Wrap the pointers with concurrent pushes and pops.
        for (int i = 0; i < 4; i++) put(32'h140 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF);
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) put(32'h180 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'hF);
        repeat (5) step();
        mem_ready = 1'b0;

        // Load hazard against a pending partial store.
        put(32'h200, 32'h00AB_0000, 4'b0100);
        ld_req  = 1'b1;
        ld_addr = 32'h204;
        #1;
        check("stall_miss", 32'(ld_stall), 32'h0);
        ld_addr = 32'h203;
        #1;
        check("stall_hit", 32'(ld_stall), 32'h1);
        mem_ready = 1'b1;
        step();
        check("stall_cleared", 32'(ld_stall), 32'h0);
        mem_ready = 1'b0;
        ld_req    = 1'b0;

        // Zero-mask store is swallowed.
        put(32'h400, 32'h1234_5678, 4'b0000);
        check("zmask_count", 32'(buf_count), 32'd0);
        check("zmask_valid", 32'(mem_valid), 32'h0);

`ifdef STBUF_COALESCE_EN
        put(32'h500, 32'h5555_5555, 4'hF);
        put(32'h300, 32'h0000_0011, 4'b0001);
        put(32'h300, 32'h0000_2200, 4'b0010);
        check("merge_count", 32'(buf_count), 32'd2);
        mem_ready = 1'b1;
        step();
        check("merge_addr", mem_addr, 32'h300);
        check("merge_mask", 32'(mem_mask), 32'h3);
        check("merge_data", mem_data, 32'h0000_2211);
        step();
        mem_ready = 1'b0;
`endif

        // Randomized traffic over a small address window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            st_valid  = ($urandom_range(0, 3) != 0);
            st_addr   = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            st_data   = $urandom;
            st_mask   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ld_req    = $urandom_range(0, 1) != 0;
            ld_addr   = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            mem_ready = ($urandom_range(0, 2) == 0);
            step();
        end
        st_valid = 1'b0;
        ld_req   = 1'b0;

        // Asynchronous reset in the middle of a handshake with three pending.
        mem_ready = 1'b1;
        repeat (6) step();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) put(32'h600 + 32'(4 * i), 32'hE000_0000 + 32'(i), 4'hF);
        mem_ready = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(mem_valid), 32'h0);
        check("arst_count", 32'(buf_count), 32'd0);
        check("arst_empty", 32'(buf_empty), 32'h1);
        check("arst_ready", 32'(st_ready), 32'h1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        put(32'h700, 32'h0F0F_0F0F, 4'hF);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Posted-write buffer directly downstream of the store unit in the RV32I core.
- Accepts byte-masked store requests (word address, lane-aligned data, 4-bit write mask), queues them in a small FIFO, and drains them to the data-memory port over a valid/ready handshake.
- Retiring stores therefore do not stall on slow memory. Loads that hit a pending store's word are stalled until that store drains.

Parameters:
DEPTH, 4, number of buffer entries; power of two, minimum 2
AW, 32, address width
DW, 32, data width; the mask width is DW/8

Ports:
clk_in  input  1  core clock
rst_n_in  input  1  asynchronous, active-low reset
st_valid_in  input  1  store request from the store unit
st_addr_in  input  AW  store byte address; bits [1:0] are ignored
st_data_in  input  DW  lane-aligned store data
st_mask_in  input  4  byte-lane write mask
st_ready_out  output  1  buffer can accept a store this cycle
ld_req_in  input  1  load request from the load path
ld_addr_in  input  AW  load byte address
ld_stall_out  output  1  load conflicts with a pending store
mem_wr_valid_out  output  1  head entry is presented to memory
mem_wr_ready_in  input  1  memory accepts the write
mem_addr_out  output  AW  head word address, bits [1:0] forced to 0
mem_data_out  output  DW  head data
mem_mask_out  output  4  head mask
buf_empty_out  output  1  no pending entries
buf_count_out  output  log2(DEPTH)+1  number of occupied entries

Behaviour:
- Reset, asynchronous, effective immediately:
  - rd_ptr, wr_ptr and count go to 0; all entry valid bits clear.
  - mem_wr_valid_out=0, buf_empty_out=1, buf_count_out=0, st_ready_out=1, ld_stall_out=0.
  - mem_addr/data/mask_out=0.
- Reset asserted mid-transfer drops the pending write. Memory must ignore writes on which valid fell without a ready.
- Enqueue when st_valid_in && st_ready_out && st_mask_in!=0:
  - Writes the entry at wr_ptr.
  - wr_ptr advances modulo DEPTH.
- A store with st_mask_in==0 is consumed and discarded: no entry is written and the count is unchanged.
- st_ready_out = (count < DEPTH). It is combinational from registered state only and does not look at mem_wr_ready_in. When the buffer is full, no enqueue happens even if a drain occurs in the same cycle.
- Drain:
  - mem_wr_valid_out = (count != 0). Outputs come from the entry at rd_ptr.
  - On mem_wr_valid_out && mem_wr_ready_in, the entry is popped and rd_ptr advances modulo DEPTH.
  - While valid && !ready, address, data and mask must stay stable. Valid must not drop except on reset.
- Latency: a store accepted at edge N appears on the mem_* outputs after edge N, i.e. in cycle N+1. Minimum occupancy is one cycle; there is no flow-through.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by count, not by pointer equality alone.
- Hazard: ld_stall_out = ld_req_in && (any occupied entry with addr[AW-1:2] == ld_addr_in[AW-1:2]).
  - Purely combinational; masks are not compared.
  - An entry being popped in the current cycle still counts as a match.
- buf_empty_out = (count == 0). buf_count_out = count.

Optional Feature:
STBUF_COALESCE_EN
- Defined: an incoming store whose word address matches the youngest occupied entry merges into that entry, provided that entry is not the head (rd_ptr) while count==1.
  - Data bytes are replaced per st_mask_in lane.
  - The entry mask becomes old_mask | st_mask_in.
  - Count and wr_ptr are unchanged.
  - A merge is accepted even when the buffer is full; st_ready_out = (count<DEPTH) || merge_hit.
- Not defined: every nonzero-mask store takes its own entry, and st_ready_out = (count<DEPTH).

Test Plan:
1. Reset, hold mem_wr_ready_in=0, enqueue 4 stores to 0x100, 0x104, 0x108, 0x10C. Expected: count=4, st_ready_out=0, a 5th store is not accepted, and mem_addr_out holds 0x100 stable.
2. Then raise mem_wr_ready_in=1 for 4 cycles. Expected: mem_addr_out sequence is 0x100, 0x104, 0x108, 0x10C, followed by buf_empty_out=1.
3. Full buffer with pops and pushes over 8+ stores. Expected: pointers wrap and order is preserved across the wrap.
4. Store to 0x200, mask 4'b0100, data 0x00AB0000 pending, then ld_req_in with ld_addr_in=0x203. Expected: ld_stall_out=1. After the store drains, ld_stall_out=0. A load to 0x204 gives ld_stall_out=0 throughout.
5. Store with mask 4'b0000. Expected: accepted, count stays 0, no memory write.
6. Pull rst_n_in low mid-handshake with count=3. Expected: mem_wr_valid_out=0 immediately and count=0.
7. With STBUF_COALESCE_EN: stores to 0x300 with mask 0001/data 0x11, then mask 0010/data 0x2200, while the head is stalled at a different word. Expected: one entry with mask 0011 and data 0x00002211.
